uart_tx_param: RTL and testbench

Parametrised UART transmitter with an input FIFO, configurable frame format and a valid/ready write interface. It is the general-purpose serial TX engine for the board: upstream logic pushes words at any rate, and the block serialises them back-to-back onto `tx_out` at a fixed baud derived from the system clock. It supersedes the fixed 8N1, single-character, switch-triggered transmitter.

---
 rtl/uart_tx_param.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// UART transmitter with an input FIFO, parametrised frame format and valid/ready write port.
// Frames are serialised back-to-back at a fixed baud of CLK_HZ/BAUD clocks per bit.
module uart_tx_param #(
    parameter int unsigned CLK_HZ     = 54000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned TW  = $clog2(DIV);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned IW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        count_q;
    logic                 push, pop, fifo_empty;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    state_e               state_q;
    logic [TW-1:0]        timer_q;
    logic [IW-1:0]        bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 tx_out_q, busy_q;
    logic                 bit_end, last_stop;

    assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = tx_valid && tx_ready;
    assign head       = mem_q[rptr_q];
    // Odd parity is the inverted XOR of the payload.
    assign head_par   = (^head) ^ (PARITY == 1);

    assign bit_end   = (timer_q == TW'(DIV - 1));
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
    assign pop       = !fifo_empty &&
                       ((state_q == StIdle) || (state_q == StStop && bit_end && last_stop));

    assign tx_out     = tx_out_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            if (state_q == StIdle || bit_end) timer_q <= '0;
            else                              timer_q <= timer_q + 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        shift_q  <= head;
                        parity_q <= head_par;
                        state_q  <= StStart;
                        tx_out_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q   <= StData;
                        bit_idx_q <= '0;
                        tx_out_q  <= shift_q[0];
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                            if (PARITY != 0) begin
                                state_q  <= StParity;
                                tx_out_q <= parity_q;
                            end else begin
                                state_q    <= StStop;
                                stop_idx_q <= 1'b0;
                                tx_out_q   <= 1'b1;
                            end
                        end else begin
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_out_q  <= shift_q[1];
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q    <= StStop;
                        stop_idx_q <= 1'b0;
                        tx_out_q   <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        if (!last_stop) begin
                            stop_idx_q <= 1'b1;
                        end else if (!fifo_empty) begin
                            // Next queued word starts immediately, no idle gap.
                            shift_q  <= head;
                            parity_q <= head_par;
                            state_q  <= StStart;
                            tx_out_q <= 1'b0;
                        end else begin
                            state_q  <= StIdle;
                            tx_out_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    tx_out_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1, 8E2, 5O1) at DIV=10, each with a
// mid-bit sampling receiver that checks frames against a queue of accepted words.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data  [3];
    logic       tx_valid [3];
    logic       tx_ready [3];
    logic       tx_o     [3];
    logic       busy     [3];
    logic [2:0] fcount   [3];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_ch
        localparam int unsigned DB  = (g == 2) ? 5 : 8;
        localparam int unsigned PAR = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int unsigned SB  = (g == 1) ? 2 : 1;
        localparam int unsigned DIV = 10;
        localparam int unsigned FL  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

        logic [7:0]  exp_q [$];
        bit          act = 1'b0;
        int unsigned cyc = 0;
        int unsigned run = 0;
        int unsigned last_run = 0;
        logic [15:0] fbits = '1;

        uart_tx_param #(
            .CLK_HZ    (1000),
            .BAUD      (100),
            .DATA_BITS (DB),
            .PARITY    (PAR),
            .STOP_BITS (SB),
            .FIFO_DEPTH(4)
        ) u_dut (
            .clk       (clk),
            .reset     (rst_n),
            .tx_data   (tx_data[g][DB-1:0]),
            .tx_valid  (tx_valid[g]),
            .tx_ready  (tx_ready[g]),
            .tx_out    (tx_o[g]),
            .busy      (busy[g]),
            .fifo_count(fcount[g])
        );

        always @(posedge clk) begin
            if (rst_n && tx_valid[g] && tx_ready[g]) exp_q.push_back(tx_data[g]);
        end

        always @(negedge clk) begin
            logic [7:0] w;
            logic       p;
            if (!rst_n) begin
                act = 1'b0;
                run = 0;
                exp_q.delete();
            end else begin
                if (busy[g]) run++;
                else if (run != 0) begin
                    last_run = run;
                    run = 0;
                end
                if (!act && !tx_o[g]) begin
                    act = 1'b1;
                    cyc = 0;
                    fbits = '1;
                    fbits[0] = 1'b0;
                    if (exp_q.size() == 0) begin
                        check($sformatf("ch%0d unexpected frame", g), exp_q.size(), 1);
                    end else begin
                        w = exp_q.pop_front();
                        p = 1'b0;
                        for (int i = 0; i < int'(DB); i++) begin
                            fbits[1+i] = w[i];
                            p ^= w[i];
                        end
                        if (PAR != 0) fbits[1+DB] = (PAR == 2) ? p : ~p;
                    end
                end
                if (act) begin
                    if (cyc % DIV == DIV / 2) begin
                        check($sformatf("ch%0d bit%0d", g, cyc / DIV), tx_o[g], fbits[cyc/DIV]);
                        check($sformatf("ch%0d busy bit%0d", g, cyc / DIV), busy[g], 1);
                    end
                    if (cyc == FL * DIV - 1) act = 1'b0;
                    else cyc++;
                end
            end
        end
    end

    task automatic push_word(input int g, input logic [7:0] w);
        bit done;
        done = 1'b0;
        tx_data[g]  = w;
        tx_valid[g] = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            done = tx_ready[g];
            @(negedge clk);
        end
        tx_valid[g] = 1'b0;
        if (!done) check("push timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while (i < budget && (busy[0] || busy[1] || busy[2] || g_ch[0].exp_q.size() != 0 ||
               g_ch[1].exp_q.size() != 0 || g_ch[2].exp_q.size() != 0)) begin
            @(negedge clk);
            i++;
        end
        check("drain timeout", (i >= budget), 0);
        @(negedge clk);
    endtask

    initial begin
        int lows;
        int highs;
        for (int g = 0; g < 3; g++) begin
            tx_valid[g] = 1'b0;
            tx_data[g]  = 8'h00;
        end

        #12;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("ch%0d reset tx_out", g), tx_o[g], 1);
            check($sformatf("ch%0d reset busy", g), busy[g], 0);
            check($sformatf("ch%0d reset count", g), fcount[g], 0);
            check($sformatf("ch%0d reset ready", g), tx_ready[g], 1);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single frames on all three channels, started on the same edge.
        tx_data[0] = 8'h41; tx_data[1] = 8'h41; tx_data[2] = 8'h1F;
        for (int g = 0; g < 3; g++) tx_valid[g] = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) tx_valid[g] = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("ch%0d count after push", g), fcount[g], 1);
            check($sformatf("ch%0d busy after push", g), busy[g], 0);
            check($sformatf("ch%0d line after push", g), tx_o[g], 1);
        end
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("ch%0d count after pop", g), fcount[g], 0);
            check($sformatf("ch%0d busy after pop", g), busy[g], 1);
            check($sformatf("ch%0d start bit", g), tx_o[g], 0);
        end
        drain(400);
        check("ch0 8N1 busy length", g_ch[0].last_run, 100);
        check("ch1 8E2 busy length", g_ch[1].last_run, 120);
        check("ch2 5O1 busy length", g_ch[2].last_run, 80);

        // Five-word burst into a four-deep FIFO.
        push_word(0, 8'h55);
        push_word(0, 8'hAA);
        push_word(0, 8'h0F);
        push_word(0, 8'hF0);
        push_word(0, 8'h81);
        check("burst count full", fcount[0], 4);
        check("burst ready low", tx_ready[0], 0);
        drain(1000);
        check("burst busy continuous", g_ch[0].last_run, 500);

        // Reset in the middle of a data bit with two words queued.
        push_word(0, 8'hA5);
        push_word(0, 8'h3C);
        push_word(0, 8'h96);
        repeat (25) @(negedge clk);
        check("pre-reset count", fcount[0], 2);
        check("pre-reset busy", busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset tx_out", tx_o[0], 1);
        check("async reset busy", busy[0], 0);
        check("async reset count", fcount[0], 0);
        check("async reset ready", tx_ready[0], 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        lows = 0;
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!tx_o[0]) lows++;
            if (busy[0]) highs++;
        end
        check("line idle after reset", lows, 0);
        check("busy idle after reset", highs, 0);

        // Push landing on the edge where the final stop period ends.
        push_word(0, 8'hC3);
        repeat (100) @(negedge clk);
        push_word(0, 8'h5A);
        check("stop-edge push idle busy", busy[0], 0);
        check("stop-edge push idle line", tx_o[0], 1);
        check("stop-edge push count", fcount[0], 1);
        @(negedge clk);
        check("stop-edge next start", tx_o[0], 0);
        check("stop-edge next busy", busy[0], 1);
        check("stop-edge next count", fcount[0], 0);
        drain(400);
        check("stop-edge frame length", g_ch[0].last_run, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
